deadlock_block_aggregator: RTL and testbench
============================================

# deadlock_block_aggregator

Collects the `block` outputs of the per-process HLS deadlock monitors in the GenerateProof dataflow hierarchy and qualifies them over time. A deadlock is declared only when one monitor holds `block` for `PERSIST` consecutive cycles. The block then latches the offending monitor index and a cycle timestamp, and presents them once on a valid/ready report port. It sits directly downstream of the monitor tree and feeds the debug/status register block.

## Interface
Parameters:
- `NUM_MON`, default 8: number of monitor `block` inputs (1..64).
- `PERSIST`, default 1024: consecutive asserted cycles required to declare a deadlock (≥1).
- `IDX_W`, default `max(1, clog2(NUM_MON))`: index width (derived).
- `CNT_W`, default `clog2(PERSIST+1)`: persistence counter width (derived).

Ports:
- `clock`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `mon_block`, in, `NUM_MON`: level `block` outputs of the monitors; bit i = monitor i.
- `clear`, in, 1: one-cycle pulse; rearms after a report.
- `report_valid`, out, 1: the report is presented.
- `report_ready`, in, 1: the consumer accepts the report.
- `report_idx`, out, `IDX_W`: index of the deadlocked monitor.
- `report_cycle`, out, 32: timestamp value when the deadlock was declared.
- `deadlock`, out, 1: sticky flag, set at declaration, cleared only by `clear` or `reset`.

## Operation
- Timestamp: free-running 32-bit counter, zeroed by reset, +1 per cycle, saturates at 0xFFFFFFFF (no wrap).
- Candidate selection: `cand` is the lowest set bit of `mon_block`.
- FSM states: IDLE, WATCH, REPORT, HOLD.
- IDLE:
  - If any bit is set: latch `cand` into `idx_r` and set `cnt <= 1`.
    - Go to REPORT if `PERSIST == 1`.
    - Otherwise go to WATCH.
- WATCH:
  - If no bit is set: go to IDLE, `cnt <= 0`.
  - Else if `cand != idx_r`: `idx_r <= cand`, `cnt <= 1`, stay in WATCH (the count restarts).
  - Else if `cnt == PERSIST-1`: go to REPORT.
  - Else: `cnt <= cnt+1`.
- Entering REPORT:
  - `report_idx <= idx_r`.
  - `report_cycle <=` the timestamp value on that edge.
  - `deadlock <= 1`.
  - `report_valid <= 1`.
- REPORT:
  - Hold `report_valid` and the data stable until `report_valid & report_ready` on an edge.
  - Then `report_valid <= 0` and go to HOLD.
- HOLD: ignore `mon_block`; wait for `clear`.
- `clear` in any state:
  - Go to IDLE, `cnt <= 0`, `deadlock <= 0`, `report_valid <= 0`.
  - `report_idx` and `report_cycle` keep their values.
  - `clear` wins over a simultaneous handshake and over a simultaneous declaration.
- `mon_block` changes while in REPORT or HOLD have no effect.

## Timing
- Reset values: `report_valid = 0`, `report_idx = 0`, `report_cycle = 0`, `deadlock = 0`, FSM in IDLE, `cnt = 0`, timestamp `= 0`.
- Latency:
  - `report_valid` and `deadlock` rise after the edge that samples the `PERSIST`-th consecutive high of the same candidate.
  - They are registered, with no combinational path from `mon_block`.
- Reset mid-operation aborts any pending report with no handshake completion; all outputs return to reset values on the next cycle.
- `report_ready` may be held high permanently. The handshake completes on the first edge where `report_valid` is high.
- One report per arming. A second deadlock is reported only after `clear`.

## Structure
- Package `deadlock_mon_pkg`:
  - State enum `dlk_state_t` {IDLE, WATCH, REPORT, HOLD}.
  - Timestamp width constant `DLK_TS_W = 32`.
- Sub-module `dlk_prio_enc`: parameterized lowest-set-bit priority encoder. Outputs `NUM_MON` → `IDX_W` index plus an `any` flag.
- Everything else (FSM, counters, report registers) lives in the top module.

## Test plan
All cases use `NUM_MON=8`, `PERSIST=4`.
- Bit 5 held from cycle 10 → `report_valid` rises after the edge at cycle 13; `report_idx = 5`; `report_cycle = 13`; `deadlock = 1`.
- Bit 2 high for 3 cycles, low 1 cycle, high again → no report until 4 fresh consecutive cycles.
- Bit 6 for 2 cycles, then bits 6 and 1 together → candidate switches to 1, count restarts; report has `idx = 1` after 4 more cycles.
- `report_ready = 0` for 5 cycles while `mon_block` changes → data stable; accept on cycle 6; `report_valid` drops; FSM is in HOLD.
- `clear` on the same edge as the handshake → `report_valid = 0`, `deadlock = 0`, FSM in IDLE; a new 4-cycle block reports again.
- `reset` asserted while in WATCH (`cnt = 3`) and while in REPORT → all outputs 0 the next cycle; timestamp restarts from 0.

Source files
------------

// File: rtl/deadlock_mon_pkg.sv
// Shared types and constants for the deadlock monitor aggregation logic.
package deadlock_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WATCH  = 2'd1,
        REPORT = 2'd2,
        HOLD   = 2'd3
    } dlk_state_t;

    localparam int DLK_TS_W = 32;

endpackage

// File: rtl/dlk_prio_enc.sv
// Lowest-set-bit priority encoder over the monitor block vector.
module dlk_prio_enc #(
    parameter int NUM_MON = 8,
    parameter int IDX_W   = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
    input  logic [NUM_MON-1:0] req_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/deadlock_block_aggregator.sv
// Qualifies monitor block levels over PERSIST cycles and reports one deadlock per arming.
//
//  state  | meaning
//  IDLE   | no monitor blocking, counter cleared
//  WATCH  | same candidate blocking, counting consecutive cycles
//  REPORT | report presented, waiting for consumer handshake
//  HOLD   | report consumed, ignoring monitors until clear
module deadlock_block_aggregator
    import deadlock_mon_pkg::*;
#(
    parameter int NUM_MON = 8,
    parameter int PERSIST = 1024,
    parameter int IDX_W   = (NUM_MON > 1) ? $clog2(NUM_MON) : 1,
    parameter int CNT_W   = $clog2(PERSIST + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_MON-1:0]  mon_block,
    input  logic                clear,
    output logic                report_valid,
    input  logic                report_ready,
    output logic [IDX_W-1:0]    report_idx,
    output logic [DLK_TS_W-1:0] report_cycle,
    output logic                deadlock
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERSIST - 1);

    dlk_state_t          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DLK_TS_W-1:0] ts_q;
    logic [DLK_TS_W-1:0] ts_d;
    logic                valid_q;
    logic                deadlock_q;
    logic [IDX_W-1:0]    rep_idx_q;
    logic [DLK_TS_W-1:0] rep_cycle_q;

    logic [IDX_W-1:0]    cand;
    logic                any_blk;

    dlk_prio_enc #(
        .NUM_MON (NUM_MON),
        .IDX_W   (IDX_W)
    ) u_prio_enc (
        .req_i (mon_block),
        .idx_o (cand),
        .any_o (any_blk)
    );

    // Timestamp saturates rather than wrapping so late reports stay ordered.
    assign ts_d = (ts_q == {DLK_TS_W{1'b1}}) ? ts_q : ts_q + DLK_TS_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            ts_q        <= '0;
            valid_q     <= 1'b0;
            deadlock_q  <= 1'b0;
            rep_idx_q   <= '0;
            rep_cycle_q <= '0;
        end else begin
            ts_q <= ts_d;
            if (clear) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                deadlock_q <= 1'b0;
                valid_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (any_blk) begin
                            idx_q <= cand;
                            cnt_q <= CNT_ONE;
                            if (PERSIST == 1) begin
                                state_q     <= REPORT;
                                rep_idx_q   <= cand;
                                rep_cycle_q <= ts_q;
                                deadlock_q  <= 1'b1;
                                valid_q     <= 1'b1;
                            end else begin
                                state_q <= WATCH;
                            end
                        end
                    end
                    WATCH: begin
                        if (!any_blk) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else if (cand != idx_q) begin
                            idx_q <= cand;
                            cnt_q <= CNT_ONE;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q     <= REPORT;
                            rep_idx_q   <= idx_q;
                            rep_cycle_q <= ts_q;
                            deadlock_q  <= 1'b1;
                            valid_q     <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    REPORT: begin
                        if (report_ready) begin
                            valid_q <= 1'b0;
                            state_q <= HOLD;
                        end
                    end
                    HOLD: begin
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign report_valid = valid_q;
    assign report_idx   = rep_idx_q;
    assign report_cycle = rep_cycle_q;
    assign deadlock     = deadlock_q;

endmodule

// File: tb/tb_deadlock_block_aggregator.sv
// Randomized and directed bench for deadlock_block_aggregator against a run-length reference model.
module tb_deadlock_block_aggregator;

    localparam int NUM_MON = 8;
    localparam int PERSIST = 4;
    localparam int IDX_W   = 3;

    logic               clock = 1'b0;
    logic               reset;
    logic [NUM_MON-1:0] mon_block;
    logic               clear;
    logic               report_valid;
    logic               report_ready;
    logic [IDX_W-1:0]   report_idx;
    logic [31:0]        report_cycle;
    logic               deadlock;

    deadlock_block_aggregator #(
        .NUM_MON (NUM_MON),
        .PERSIST (PERSIST)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .mon_block    (mon_block),
        .clear        (clear),
        .report_valid (report_valid),
        .report_ready (report_ready),
        .report_idx   (report_idx),
        .report_cycle (report_cycle),
        .deadlock     (deadlock)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: armed / presenting / consumed, plus run length of the current lowest bit.
    int          m_mode = 0;
    int          m_run  = 0;
    int          m_prev = -1;
    logic        m_valid = 1'b0;
    logic        m_dead  = 1'b0;
    logic [2:0]  m_idx   = '0;
    logic [31:0] m_cycle = '0;
    logic [31:0] m_ts    = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lowest_bit(input logic [NUM_MON-1:0] v);
        for (int i = 0; i < NUM_MON; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_edge();
        int c;
        if (reset) begin
            m_mode = 0; m_run = 0; m_prev = -1;
            m_valid = 1'b0; m_dead = 1'b0; m_idx = '0; m_cycle = '0; m_ts = '0;
            return;
        end
        if (clear) begin
            m_mode = 0; m_run = 0; m_valid = 1'b0; m_dead = 1'b0;
        end else if (m_mode == 0) begin
            c = lowest_bit(mon_block);
            if (c < 0) m_run = 0;
            else m_run = (m_run > 0 && c == m_prev) ? m_run + 1 : 1;
            m_prev = c;
            if (m_run == PERSIST) begin
                m_mode = 1; m_valid = 1'b1; m_dead = 1'b1;
                m_idx = 3'(c); m_cycle = m_ts;
            end
        end else if (m_mode == 1) begin
            if (report_ready) begin
                m_mode = 2; m_valid = 1'b0;
            end
        end
        if (m_ts != 32'hFFFF_FFFF) m_ts = m_ts + 1;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        chk("valid", {31'd0, report_valid}, {31'd0, m_valid});
        chk("deadlock", {31'd0, deadlock}, {31'd0, m_dead});
        chk("idx", {29'd0, report_idx}, {29'd0, m_idx});
        chk("cycle", report_cycle, m_cycle);
    endtask

    task automatic drive(input logic [7:0] mon, input logic rdy, input logic clr,
                         input logic rst, input int n);
        mon_block = mon; report_ready = rdy; clear = clr; reset = rst;
        repeat (n) step();
    endtask

    task automatic chk_out(input string tag, input logic v, input logic d,
                           input logic [2:0] ix, input logic [31:0] cy);
        chk({tag, "_valid"}, {31'd0, report_valid}, {31'd0, v});
        chk({tag, "_dead"}, {31'd0, deadlock}, {31'd0, d});
        chk({tag, "_idx"}, {29'd0, report_idx}, {29'd0, ix});
        chk({tag, "_cycle"}, report_cycle, cy);
    endtask

    initial begin
        mon_block = '0; report_ready = 1'b0; clear = 1'b0; reset = 1'b1;
        #1;
        drive(8'h00, 1'b0, 1'b0, 1'b1, 2);
        chk_out("rst", 1'b0, 1'b0, 3'd0, 32'd0);

        // Bit 5 from cycle 10, consumer stalled
        drive(8'h00, 1'b0, 1'b0, 1'b0, 10);
        drive(8'h20, 1'b0, 1'b0, 1'b0, 3);
        chk_out("pre", 1'b0, 1'b0, 3'd0, 32'd0);
        drive(8'h20, 1'b0, 1'b0, 1'b0, 1);
        chk_out("t1", 1'b1, 1'b1, 3'd5, 32'd13);
        for (int i = 0; i < 4; i++)
            drive(8'($urandom), 1'b0, 1'b0, 1'b0, 1);
        chk_out("stall", 1'b1, 1'b1, 3'd5, 32'd13);
        drive(8'h01, 1'b1, 1'b0, 1'b0, 1);
        chk_out("accept", 1'b0, 1'b1, 3'd5, 32'd13);
        drive(8'h04, 1'b1, 1'b0, 1'b0, 8);
        chk_out("hold", 1'b0, 1'b1, 3'd5, 32'd13);
        drive(8'h04, 1'b1, 1'b1, 1'b0, 1);
        chk_out("clr", 1'b0, 1'b0, 3'd5, 32'd13);

        // Broken run of bit 2, then a fresh run of 4
        drive(8'h04, 1'b0, 1'b0, 1'b0, 3);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1);
        drive(8'h04, 1'b0, 1'b0, 1'b0, 3);
        chk("t2_none", {31'd0, report_valid}, 32'd0);
        drive(8'h04, 1'b0, 1'b0, 1'b0, 1);
        chk("t2_rep", {31'd0, report_valid}, 32'd1);
        chk("t2_idx", {29'd0, report_idx}, 32'd2);
        drive(8'h04, 1'b1, 1'b1, 1'b0, 1);

        // Candidate switch from 6 to 1 restarts the count
        drive(8'h40, 1'b0, 1'b0, 1'b0, 2);
        drive(8'h42, 1'b0, 1'b0, 1'b0, 3);
        chk("t3_none", {31'd0, report_valid}, 32'd0);
        drive(8'h42, 1'b0, 1'b0, 1'b0, 1);
        chk("t3_idx", {29'd0, report_idx}, 32'd1);

        // Clear coincident with handshake, then rearm
        drive(8'h42, 1'b1, 1'b1, 1'b0, 1);
        chk("t5_valid", {31'd0, report_valid}, 32'd0);
        chk("t5_dead", {31'd0, deadlock}, 32'd0);
        drive(8'h08, 1'b0, 1'b0, 1'b0, 4);
        chk("t5_rearm", {31'd0, report_valid}, 32'd1);
        chk("t5_idx", {29'd0, report_idx}, 32'd3);

        // Reset mid-WATCH and mid-REPORT
        drive(8'h00, 1'b0, 1'b1, 1'b0, 1);
        drive(8'h02, 1'b0, 1'b0, 1'b0, 3);
        drive(8'h02, 1'b0, 1'b0, 1'b1, 1);
        chk_out("rst_w", 1'b0, 1'b0, 3'd0, 32'd0);
        drive(8'h01, 1'b0, 1'b0, 1'b0, 4);
        chk_out("ts_restart", 1'b1, 1'b1, 3'd0, 32'd3);
        drive(8'h01, 1'b1, 1'b0, 1'b1, 1);
        chk_out("rst_r", 1'b0, 1'b0, 3'd0, 32'd0);

        // Randomized traffic against the model
        mon_block = '0; reset = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(5) == 0) begin
                case ($urandom_range(3))
                    0: mon_block = '0;
                    1: mon_block = 8'(1) << $urandom_range(7);
                    default: mon_block = 8'($urandom);
                endcase
            end
            report_ready = ($urandom_range(2) != 0);
            clear        = ($urandom_range(39) == 0);
            reset        = ($urandom_range(499) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
